clock_divider_ctrl: RTL and testbench
=====================================

CLOCK_DIVIDER_CTRL -- requirements
Module: clock_divider_ctrl

Interface
REQ-001 Parameter CNT_W, default 8: width of the divide-ratio field and the period counter.
REQ-002 Parameter DEFAULT_DIV, default 4: divide ratio loaded at reset; legal range 2..2^CNT_W-1.
REQ-003 clk  input  1: single clock; all state SHALL be on its rising edge.
REQ-004 reset  input  1: asynchronous, active-low reset (0 = reset asserted).
REQ-005 enable  input  1: level request to run the divided clock.
REQ-006 cfg_valid  input  1: new divide ratio offered.
REQ-007 cfg_div  input  CNT_W: offered divide ratio N.
REQ-008 cfg_ready  output  1: controller can accept a ratio this cycle.
REQ-009 clk_out  output  1: divided clock, flop-driven.
REQ-010 tick  output  1: one-cycle pulse marking the first clk cycle of each output period.
REQ-011 busy  output  1: a ratio update is pending.
REQ-012 cfg_err  output  1: one-cycle pulse flagging a rejected ratio.

Function
REQ-013 State: IDLE, RUN, PEND. Registers: count[CNT_W-1:0], div_act, div_pend.
REQ-014 All outputs SHALL be driven directly from flops, with no combinational path from inputs to outputs.
REQ-015 clk_out SHALL be 1 exactly in the cycles where state != IDLE and count < (div_act >> 1); otherwise 0.
REQ-016 For odd N, the high phase is floor(N/2) cycles and the low phase is the remainder.
REQ-017 tick SHALL be 1 exactly in the cycles where state != IDLE and count == 0.
REQ-018 IDLE: count held at 0. If enable = 1 at an edge, the next state SHALL be RUN with count = 0, so clk_out and tick rise one cycle after enable is sampled.
REQ-019 RUN/PEND: count SHALL increment by 1 per cycle. At count == div_act-1 (the wrap), count SHALL return to 0.
REQ-020 enable = 0 sampled in RUN/PEND SHALL be honoured only at the wrap cycle, returning to IDLE so that no truncated period occurs.
REQ-021 If enable returns to 1 before the wrap, the controller SHALL keep running without interruption.
REQ-022 cfg_ready SHALL be 1 in IDLE and RUN, and 0 in PEND.
REQ-023 Handshake completes when cfg_valid & cfg_ready are both 1 at an edge.
REQ-024 An accepted cfg_div < 2 SHALL be rejected: cfg_err pulses high the next cycle, and no state or ratio changes.
REQ-025 An accepted legal ratio in IDLE SHALL load div_act at that edge, with no busy assertion.
REQ-026 An accepted legal ratio in RUN SHALL load div_pend and move the controller to PEND, with busy = 1 from the next cycle.
REQ-027 In PEND, at the wrap: div_act <= div_pend, count <= 0, state <= RUN (or IDLE if enable = 0), and busy deasserts.
REQ-028 The new ratio SHALL take effect from the first cycle of the next period.
REQ-029 A handshake coinciding with a RUN wrap SHALL be applied at the following wrap, not the current one.
REQ-030 Ratio N = 2^CNT_W-1 SHALL be supported without counter overflow.

Reset
REQ-031 While reset = 0, asynchronously: state = IDLE, count = 0, div_act = DEFAULT_DIV, div_pend = DEFAULT_DIV, clk_out = 0, tick = 0, busy = 0, cfg_err = 0.
REQ-032 While reset = 0, cfg_ready SHALL be 0; it rises to 1 on the first clk edge after reset = 1.
REQ-033 Reset asserted mid-period or in PEND SHALL discard any pending ratio.

Verification
REQ-034 Reset release, enable = 1, default N = 4 -> clk_out pattern 1,1,0,0 repeating; tick every 4th cycle, aligned with the clk_out rise.
REQ-035 In IDLE, cfg_div = 5 accepted, then enable = 1 -> clk_out high 2 cycles, low 3 cycles; period 5; busy never asserted.
REQ-036 Running N = 4, cfg_div = 6 accepted at count = 1 -> busy = 1, cfg_ready = 0 until the wrap; next period is 1,1,1,0,0,0 and busy returns to 0.
REQ-037 cfg_div = 0 and cfg_div = 1 offered -> cfg_err pulse on each, with no change to period or busy.
REQ-038 Running N = 4, enable drops at count = 1 -> two more cycles of the current period, then clk_out = 0, tick = 0 and state IDLE; an enable re-pulse before the wrap causes no gap.
REQ-039 reset asserted in PEND at count = 2 -> all outputs return to reset values immediately; after release and enable = 1, the period is DEFAULT_DIV.

Source files
------------

// File: rtl/clock_divider_ctrl.sv
// clock_divider_ctrl: programmable clock divider with ratio handshake, whole-period start/stop and deferred ratio update (ports: clk, reset(active-low async), enable, cfg_valid/cfg_div/cfg_ready, clk_out, tick, busy, cfg_err)
module clock_divider_ctrl #(
  parameter int CNT_W = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic             cfg_err
);
  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] MIN = CNT_W'(2);
  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] count, count_nx, div_act, div_act_nx, div_pend, div_pend_nx;
  logic acc, bad, wrap;
  always_comb begin
    acc = cfg_valid & cfg_ready & (cfg_div >= MIN);
    bad = cfg_valid & cfg_ready & (cfg_div < MIN);
    wrap = (state != IDLE) && (count == div_act - 1'b1);
    state_nx = state;
    count_nx = count + 1'b1;
    div_act_nx = div_act;
    div_pend_nx = div_pend;
    if (state == IDLE) begin
      count_nx = '0;
      if (acc) div_act_nx = cfg_div;
      if (enable) state_nx = RUN;
    end else if (wrap) begin
      count_nx = '0;
      if (state == PEND) div_act_nx = div_pend;
      state_nx = enable ? RUN : IDLE;
      if (acc && enable) begin
        state_nx = PEND;
        div_pend_nx = cfg_div;
      end else if (acc) begin
        div_act_nx = cfg_div;
      end
    end else if (acc) begin
      state_nx = PEND;
      div_pend_nx = cfg_div;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      div_act <= DEF;
      div_pend <= DEF;
      clk_out <= 1'b0;
      tick <= 1'b0;
      busy <= 1'b0;
      cfg_err <= 1'b0;
      cfg_ready <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      div_act <= div_act_nx;
      div_pend <= div_pend_nx;
      clk_out <= (state_nx != IDLE) && (count_nx < (div_act_nx >> 1));
      tick <= (state_nx != IDLE) && (count_nx == '0);
      busy <= state_nx == PEND;
      cfg_err <= bad;
      cfg_ready <= state_nx != PEND;
    end
  end
endmodule

// File: tb/tb_clock_divider_ctrl.sv
// tb_clock_divider_ctrl: directed plus random stimulus checked cycle by cycle against a period-level reference model
module tb_clock_divider_ctrl;
  localparam int W = 8;
  logic clk = 1'b0, reset = 1'b0, enable = 1'b0, cfg_valid = 1'b0;
  logic [W-1:0] cfg_div = '0;
  logic cfg_ready, clk_out, tick, busy, cfg_err;
  int errors = 0, checks = 0;
  int ratio, pend_ratio, pos;
  bit running, pending, rdy, err;
  clock_divider_ctrl #(.CNT_W(W), .DEFAULT_DIV(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .clk_out(clk_out), .tick(tick), .busy(busy), .cfg_err(cfg_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask
  task automatic model_reset();
    ratio = 4; pend_ratio = 4; pos = 0;
    running = 0; pending = 0; rdy = 0; err = 0;
  endtask
  task automatic model_step(input bit en, input bit v, input int d);
    bit acc, wrap;
    acc = v && rdy;
    err = acc && d < 2;
    acc = acc && d >= 2;
    wrap = running && pos == ratio - 1;
    if (!running) begin
      if (acc) ratio = d;
      running = en;
      pos = 0;
    end else if (wrap) begin
      if (pending) ratio = pend_ratio;
      pending = 0;
      pos = 0;
      running = en;
      if (acc && en) begin pending = 1; pend_ratio = d; end
      else if (acc) ratio = d;
    end else begin
      pos++;
      if (acc) begin pending = 1; pend_ratio = d; end
    end
    rdy = !pending;
  endtask
  task automatic check_all();
    check("clk_out", clk_out, running && pos < ratio / 2);
    check("tick", tick, running && pos == 0);
    check("busy", busy, pending);
    check("cfg_ready", cfg_ready, rdy);
    check("cfg_err", cfg_err, err);
  endtask
  task automatic cycle(input bit en, input bit v, input int d);
    enable = en; cfg_valid = v; cfg_div = W'(d);
    @(posedge clk);
    model_step(en, v, d);
    #1 check_all();
  endtask
  initial begin
    model_reset();
    #12 check_all();
    reset = 1'b1;
    for (int i = 0; i < 9; i++) cycle(1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0);
    cycle(0, 1, 5);
    for (int i = 0; i < 11; i++) cycle(1, 0, 0);
    cycle(1, 1, 4);
    for (int i = 0; i < 6; i++) cycle(1, 0, 0);
    cycle(1, 1, 6);
    for (int i = 0; i < 12; i++) cycle(1, 0, 0);
    cycle(1, 1, 0);
    cycle(1, 1, 1);
    for (int i = 0; i < 6; i++) cycle(1, 0, 0);
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    cycle(1, 1, 9);
    cycle(1, 0, 0);
    reset = 1'b0;
    model_reset();
    #1 check_all();
    #3 reset = 1'b1;
    for (int i = 0; i < 9; i++) cycle(1, 0, 0);
    cycle(1, 1, 255);
    for (int i = 0; i < 520; i++) cycle(i < 500, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      int r, d;
      r = $urandom_range(0, 19);
      d = r == 0 ? $urandom_range(0, 1) : r == 1 ? 255 : $urandom_range(2, 9);
      cycle($urandom_range(0, 9) < 8, $urandom_range(0, 3) == 0, d);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
